// File: rtl/r2mdc_stage_ctrl.sv
// r2mdc_stage_ctrl: beat sequencer for one radix-2 MDC FFT stage.
// Drives twiddle index, commutator select, delay-line enable and framing.
module r2mdc_stage_ctrl #(
   parameter int N     = 16,
   parameter int STAGE = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic                   in_sof,
   output logic                   in_ready,
   output logic [$clog2(N)-2:0]   tw_addr,
   output logic                   bf_valid,
   output logic                   sw_sel,
   output logic                   dl_en,
   output logic                   out_valid,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   err
);

   localparam int LOGN = $clog2(N);
   localparam int AW   = LOGN - 1;
   localparam int KW   = LOGN;
   localparam int HALF = N / 2;
   localparam int D    = N >> (STAGE + 1);
   localparam int LOGD = $clog2(D);

   localparam logic [AW-1:0] DMASK = AW'(D - 1);
   localparam logic [AW-1:0] CLAST = AW'(HALF - 1);
   localparam logic [AW:0]   FD    = (AW + 1)'(D);
   localparam logic [KW-1:0] KD    = KW'(D);
   localparam logic [KW-1:0] KLAST = KW'(HALF + D - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t        state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] c;
   logic [AW:0]   cx;
   logic [AW:0]   fc;
   logic [KW-1:0] k;
   logic [KW-1:0] kc;
   logic          acc;
   logic          sof_beat;
   logic          run_beat;
   logic          beat;
   logic          pulse;
   logic          err_nxt;

   assign in_ready = (state != FLUSH);

   // c/kc are the beat and pulse indices this cycle; a SOF restarts both
   always_comb begin
      acc      = in_valid & in_ready;
      sof_beat = acc & in_sof;
      run_beat = acc & ~in_sof & (state == RUN);
      beat     = sof_beat | run_beat;
      pulse    = beat | (state == FLUSH);
      c        = sof_beat ? '0 : cnt;
      cx       = {1'b0, c};
      kc       = sof_beat ? '0 : k;
      err_nxt  = (sof_beat & (state == RUN) & (cnt != '0))
               | (acc & ~in_sof & (state == IDLE));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         fc        <= '0;
         k         <= '0;
         tw_addr   <= '0;
         sw_sel    <= 1'b0;
         bf_valid  <= 1'b0;
         dl_en     <= 1'b0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eof   <= 1'b0;
         err       <= 1'b0;
      end else begin
         err       <= err_nxt;
         bf_valid  <= beat;
         dl_en     <= pulse;
         out_valid <= pulse & (kc >= KD);
         out_sof   <= pulse & (kc == KD);
         out_eof   <= pulse & (kc == KLAST);
         if (pulse)
            k <= kc + KW'(1);
         if (beat) begin
            tw_addr <= (c & DMASK) << STAGE;
            sw_sel  <= cx[LOGD];
         end
         unique case (state)
            IDLE: begin
               if (sof_beat) begin
                  cnt   <= AW'(1);
                  state <= RUN;
               end
            end
            RUN: begin
               if (sof_beat) begin
                  cnt <= AW'(1);
               end else if (run_beat) begin
                  if (cnt == CLAST) begin
                     cnt   <= '0;
                     fc    <= FD;
                     state <= FLUSH;
                  end else begin
                     cnt <= cnt + AW'(1);
                  end
               end
            end
            FLUSH: begin
               fc <= fc - (AW + 1)'(1);
               if (fc == (AW + 1)'(1))
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
